page_ctrl: RTL and testbench

Top-level page sequencer for the VGA front end. It owns the Start / Game / Game-Over page state machine and drives one registered 16-bit pixel mux that selects `page_start`, game-field, or game-over pixels. Page changes happen only on frame boundaries, so a frame never shows two pages. It also produces the game-logic reset and the blink enable for the "PRESS ANY KEY" text.

---
 rtl/page_ctrl.sv | 113 +++++++++++
 tb/tb_page_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/page_ctrl.sv
// Page sequencer for the VGA front end: Start / Game / Game-Over state machine,
// registered pixel mux, game-logic reset and "PRESS ANY KEY" blink enable.
module page_ctrl #(
    parameter int FRAME_HOLD   = 30,
    parameter int OVER_FRAMES  = 180,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        frame_start,
    input  logic        key_valid,
    input  logic        game_over,
    input  logic [15:0] start_pix,
    input  logic [15:0] game_pix,
    input  logic [15:0] over_pix,
    output logic [15:0] pix_data,
    output logic [1:0]  page,
    output logic        game_rst_n,
    output logic        blink_on,
    output logic        page_change
);

    typedef enum logic [1:0] {
        PG_START = 2'd0,
        PG_GAME  = 2'd1,
        PG_OVER  = 2'd2
    } page_t;

    localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [8:0] HOLD_MIN   = 9'(FRAME_HOLD);

    page_t      state;
    page_t      state_nxt;
    logic [7:0] fcnt;
    logic [7:0] bcnt;
    logic       key_pend;
    logic       over_seen;
    logic       key_eff;
    logic       over_eff;
    logic       hold_ok;
    logic       change;

    assign page     = state;
    assign key_eff  = key_pend | key_valid;
    assign over_eff = over_seen | game_over;
    // Equivalent to fcnt >= FRAME_HOLD, but stays a real compare when FRAME_HOLD = 0.
    assign hold_ok  = ({1'b0, fcnt} + 9'd1) > HOLD_MIN;
    assign change   = (state_nxt != state);

    // NOTE: default assignment first so no path through the block leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            case (state)
                PG_START: if (key_eff && hold_ok)                          state_nxt = PG_GAME;
                PG_GAME:  if (over_eff)                                    state_nxt = PG_OVER;
                PG_OVER:  if ((fcnt >= OVER_LAST) || (key_eff && hold_ok)) state_nxt = PG_START;
                default:                                                   state_nxt = PG_START;
            endcase
        end
    end

    // NOTE: all state uses non-blocking assignments and the reset is sampled on the clock edge.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            state       <= PG_START;
            pix_data    <= 16'h0000;
            game_rst_n  <= 1'b0;
            blink_on    <= 1'b1;
            page_change <= 1'b0;
            fcnt        <= 8'd0;
            bcnt        <= 8'd0;
            key_pend    <= 1'b0;
            over_seen   <= 1'b0;
        end else begin
            state       <= state_nxt;
            page_change <= change;
            game_rst_n  <= (state_nxt == PG_GAME);

            // Mux keys off the registered page, so the new page's pixel appears one cycle after page.
            case (state)
                PG_START: pix_data <= start_pix;
                PG_GAME:  pix_data <= game_pix;
                PG_OVER:  pix_data <= over_pix;
                default:  pix_data <= 16'h0000;
            endcase

            // A key is only ever good for the next boundary; it never carries across one.
            if (frame_start) key_pend <= 1'b0;
            else if (key_valid) key_pend <= 1'b1;

            if (change) over_seen <= 1'b0;
            else if (state == PG_GAME && game_over) over_seen <= 1'b1;

            if (change) fcnt <= 8'd0;
            else if (frame_start && fcnt != 8'hFF) fcnt <= fcnt + 8'd1;

            if (change || state_nxt != PG_START) begin
                bcnt     <= 8'd0;
                blink_on <= 1'b1;
            end else if (frame_start) begin
                if (bcnt == BLINK_LAST) begin
                    bcnt     <= 8'd0;
                    blink_on <= ~blink_on;
                end else begin
                    bcnt <= bcnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_page_ctrl.sv
// Directed bench for page_ctrl: hold window, over latch, auto return, blink,
// synchronous reset and zero-hold behaviour, with hand-computed expectations.
module tb_page_ctrl;

    localparam logic [15:0] START_PIX = 16'h07E0;
    localparam logic [15:0] GAME_PIX  = 16'h001F;
    localparam logic [15:0] OVER_PIX  = 16'hF800;

    logic        vga_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        rst0_n      = 1'b0;
    logic        frame_start = 1'b0;
    logic        key_valid   = 1'b0;
    logic        game_over   = 1'b0;
    logic [15:0] start_pix   = START_PIX;
    logic [15:0] game_pix    = GAME_PIX;
    logic [15:0] over_pix    = OVER_PIX;

    logic [15:0] pix_data;
    logic [1:0]  page;
    logic        game_rst_n, blink_on, page_change;

    logic [15:0] pix_data0;
    logic [1:0]  page0;
    logic        game_rst_n0, blink_on0, page_change0;

    int errors = 0;
    int checks = 0;

    page_ctrl #(.FRAME_HOLD(2), .OVER_FRAMES(3), .BLINK_FRAMES(4)) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start),
        .key_valid(key_valid), .game_over(game_over), .start_pix(start_pix),
        .game_pix(game_pix), .over_pix(over_pix), .pix_data(pix_data), .page(page),
        .game_rst_n(game_rst_n), .blink_on(blink_on), .page_change(page_change)
    );

    // Zero-hold instance, held in reset until its own scenario.
    page_ctrl #(.FRAME_HOLD(0), .OVER_FRAMES(3), .BLINK_FRAMES(4)) dut0 (
        .vga_clk(vga_clk), .sys_rst_n(rst0_n), .frame_start(frame_start),
        .key_valid(key_valid), .game_over(game_over), .start_pix(start_pix),
        .game_pix(game_pix), .over_pix(over_pix), .pix_data(pix_data0), .page(page0),
        .game_rst_n(game_rst_n0), .blink_on(blink_on0), .page_change(page_change0)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_key();
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        idle(2);
        checks++; if (page !== 2'd0) begin errors++; $display("FAIL reset_page: got %0d want 0", page); end
        checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL reset_pix: got %h want 0000", pix_data); end
        checks++; if (game_rst_n !== 1'b0) begin errors++; $display("FAIL reset_game_rst_n: got %b want 0", game_rst_n); end
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL reset_blink: got %b want 1", blink_on); end
        checks++; if (page_change !== 1'b0) begin errors++; $display("FAIL reset_page_change: got %b want 0", page_change); end
        sys_rst_n = 1'b1;
        tick();
        checks++; if (pix_data !== START_PIX) begin errors++; $display("FAIL reset_release_pix: got %h want %h", pix_data, START_PIX); end
    endtask

    task automatic test_hold_window();
        pulse_key();
        idle(2);
        pulse_fs();
        checks++; if (page !== 2'd0) begin errors++; $display("FAIL hold_b1_page: got %0d want 0", page); end
        idle(3);
        pulse_fs();
        checks++; if (page !== 2'd0) begin errors++; $display("FAIL hold_b2_page: got %0d want 0", page); end
        checks++; if (page_change !== 1'b0) begin errors++; $display("FAIL hold_b2_change: got %b want 0", page_change); end
        idle(2);
        pulse_key();
        idle(2);
        pulse_fs();
        checks++; if (page !== 2'd1) begin errors++; $display("FAIL hold_b3_page: got %0d want 1", page); end
        checks++; if (page_change !== 1'b1) begin errors++; $display("FAIL hold_b3_change: got %b want 1", page_change); end
        checks++; if (game_rst_n !== 1'b1) begin errors++; $display("FAIL hold_b3_game_rst_n: got %b want 1", game_rst_n); end
        checks++; if (pix_data !== START_PIX) begin errors++; $display("FAIL hold_b3_pix: got %h want %h", pix_data, START_PIX); end
        tick();
        checks++; if (page_change !== 1'b0) begin errors++; $display("FAIL hold_change_once: got %b want 0", page_change); end
        checks++; if (pix_data !== GAME_PIX) begin errors++; $display("FAIL hold_game_pix: got %h want %h", pix_data, GAME_PIX); end
    endtask

    task automatic test_over_latch();
        pulse_key();
        idle(1);
        pulse_fs();
        checks++; if (page !== 2'd1) begin errors++; $display("FAIL over_key_ignored: got %0d want 1", page); end
        idle(2);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        idle(3);
        checks++; if (page !== 2'd1) begin errors++; $display("FAIL over_mid_frame_page: got %0d want 1", page); end
        pulse_fs();
        checks++; if (page !== 2'd2) begin errors++; $display("FAIL over_page: got %0d want 2", page); end
        checks++; if (page_change !== 1'b1) begin errors++; $display("FAIL over_change: got %b want 1", page_change); end
        checks++; if (game_rst_n !== 1'b0) begin errors++; $display("FAIL over_game_rst_n: got %b want 0", game_rst_n); end
        checks++; if (pix_data !== GAME_PIX) begin errors++; $display("FAIL over_pix_t1: got %h want %h", pix_data, GAME_PIX); end
        tick();
        checks++; if (pix_data !== OVER_PIX) begin errors++; $display("FAIL over_pix_t2: got %h want %h", pix_data, OVER_PIX); end
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL over_blink: got %b want 1", blink_on); end
    endtask

    task automatic test_auto_return();
        for (int b = 1; b <= 3; b++) begin
            logic [1:0] exp_page;
            exp_page = (b < 3) ? 2'd2 : 2'd0;
            idle(2);
            pulse_fs();
            checks++; if (page !== exp_page) begin errors++; $display("FAIL auto_b%0d_page: got %0d want %0d", b, page, exp_page); end
        end
        checks++; if (page_change !== 1'b1) begin errors++; $display("FAIL auto_change: got %b want 1", page_change); end
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL auto_blink: got %b want 1", blink_on); end
        tick();
        checks++; if (pix_data !== START_PIX) begin errors++; $display("FAIL auto_pix: got %h want %h", pix_data, START_PIX); end
    endtask

    task automatic test_blink();
        for (int k = 1; k <= 12; k++) begin
            logic exp_blink;
            exp_blink = ((k / 4) % 2) == 0;
            idle(3);
            pulse_fs();
            checks++; if (blink_on !== exp_blink) begin errors++; $display("FAIL blink_b%0d: got %b want %b", k, blink_on, exp_blink); end
            checks++; if (page !== 2'd0) begin errors++; $display("FAIL blink_b%0d_page: got %0d want 0", k, page); end
        end
    endtask

    task automatic test_same_cycle_key();
        idle(2);
        key_valid   = 1'b1;
        frame_start = 1'b1;
        tick();
        key_valid   = 1'b0;
        frame_start = 1'b0;
        checks++; if (page !== 2'd1) begin errors++; $display("FAIL same_key_page: got %0d want 1", page); end
        checks++; if (page_change !== 1'b1) begin errors++; $display("FAIL same_key_change: got %b want 1", page_change); end
        checks++; if (game_rst_n !== 1'b1) begin errors++; $display("FAIL same_key_game_rst_n: got %b want 1", game_rst_n); end
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL same_key_blink: got %b want 1", blink_on); end
    endtask

    task automatic test_sync_reset_game();
        idle(2);
        pulse_key();
        idle(1);
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        checks++; if (page !== 2'd0) begin errors++; $display("FAIL srst_page: got %0d want 0", page); end
        checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL srst_pix: got %h want 0000", pix_data); end
        checks++; if (game_rst_n !== 1'b0) begin errors++; $display("FAIL srst_game_rst_n: got %b want 0", game_rst_n); end
        idle(2);
        pulse_fs();
        checks++; if (page !== 2'd0) begin errors++; $display("FAIL srst_no_transition: got %0d want 0", page); end
        checks++; if (page_change !== 1'b0) begin errors++; $display("FAIL srst_no_change: got %b want 0", page_change); end
    endtask

    task automatic test_zero_hold();
        rst0_n = 1'b1;
        tick();
        pulse_key();
        idle(1);
        pulse_fs();
        checks++; if (page0 !== 2'd1) begin errors++; $display("FAIL zero_hold_page: got %0d want 1", page0); end
        checks++; if (game_rst_n0 !== 1'b1) begin errors++; $display("FAIL zero_hold_game_rst_n: got %b want 1", game_rst_n0); end
        pulse_key();
        tick();
        rst0_n = 1'b0;
        tick();
        rst0_n = 1'b1;
        checks++; if (page0 !== 2'd0) begin errors++; $display("FAIL zero_srst_page: got %0d want 0", page0); end
        checks++; if (pix_data0 !== 16'h0000) begin errors++; $display("FAIL zero_srst_pix: got %h want 0000", pix_data0); end
        idle(2);
        pulse_fs();
        checks++; if (page0 !== 2'd0) begin errors++; $display("FAIL zero_key_discarded: got %0d want 0", page0); end
    endtask

    initial begin
        test_reset();
        test_hold_window();
        test_over_latch();
        test_auto_return();
        test_blink();
        test_same_cycle_key();
        test_sync_reset_game();
        test_zero_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
